// File: rtl/melody_seq.sv
// melody_seq: note sequencer feeding the divider input of the square-wave
// tone generator. Plays a small program of (div, duration) entries in order,
// with an optional silent gap after each note, single-shot or looping.
module melody_seq #(
  parameter int WIDTH_COUNTER = 10,
  parameter int DEPTH         = 8,
  parameter int WIDTH_DUR     = 8,
  parameter int TICK_DIV      = 1000,
  parameter int GAP_CLKS      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH_COUNTER-1:0]   wr_div,
  input  logic [WIDTH_DUR-1:0]       wr_dur,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic [$clog2(DEPTH):0]     len,
  output logic [WIDTH_COUNTER-1:0]   div,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   note_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);
  localparam logic [AW:0]   DEPTH_L     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Program storage
  logic [WIDTH_COUNTER-1:0] r_mem_div [DEPTH];
  logic [WIDTH_DUR-1:0]     r_mem_dur [DEPTH];

  // Sequencer state and registered outputs
  state_t                   r_state;
  logic [WIDTH_COUNTER-1:0] r_div;
  logic                     r_busy;
  logic                     r_done;
  logic [AW-1:0]            r_note_idx;
  logic [TW-1:0]            r_tick;
  logic [WIDTH_DUR-1:0]     r_dur;
  logic [GW-1:0]            r_gap;
  logic [AW-1:0]            r_last;
  logic                     r_loop;

  // Decode signals
  logic                     w_start_ok;
  logic [AW-1:0]            w_last;
  logic                     w_at_last;
  logic                     w_more;
  logic                     w_note_end;
  logic                     w_finish;
  logic                     w_enter;
  logic [AW-1:0]            w_entry_idx;
  logic [WIDTH_COUNTER-1:0] w_entry_div;
  logic [WIDTH_DUR-1:0]     w_entry_dur;

  assign div      = r_div;
  assign busy     = r_busy;
  assign done     = r_done;
  assign note_idx = r_note_idx;

  // Program write port; reset clears every entry to a silent end marker
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_div[i] <= '0;
        r_mem_dur[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem_div[wr_addr] <= wr_div;
      r_mem_dur[wr_addr] <= wr_dur;
    end
  end

  // Start qualification, end-of-note detection and next-entry selection
  always_comb begin
    w_start_ok  = (r_state == IDLE) && start && !stop && (len != '0);
    w_last      = (len > DEPTH_L) ? LAST_MAX : AW'(len - 1'b1);
    w_at_last   = (r_note_idx == r_last);
    w_more      = !w_at_last || r_loop;
    w_note_end  = (r_state == PLAY) && (r_tick == '0) && (r_dur == WIDTH_DUR'(1));
    // A note is finished either at the end of its gap or, without gaps,
    // directly at the end of the note itself.
    w_finish    = (w_note_end && (GAP_CLKS == 0)) || ((r_state == GAP) && (r_gap == '0));
    w_enter     = w_start_ok || (w_finish && w_more);
    w_entry_idx = (w_start_ok || w_at_last) ? '0 : AW'(r_note_idx + 1'b1);
    w_entry_div = r_mem_div[w_entry_idx];
    w_entry_dur = r_mem_dur[w_entry_idx];
  end

  // Playback FSM: stop beats every other event; entries are read only on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
      r_tick     <= '0;
      r_dur      <= '0;
      r_gap      <= '0;
      r_last     <= '0;
      r_loop     <= 1'b0;
    end else if (stop && (r_state != IDLE)) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_enter) begin
      if (w_start_ok) begin
        r_loop <= loop;
        r_last <= w_last;
      end
      if (w_entry_dur == '0) begin
        // End marker: the entry is never played
        r_state <= DONE;
        r_div   <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b1;
      end else begin
        r_state    <= PLAY;
        r_div      <= w_entry_div;
        r_note_idx <= w_entry_idx;
        r_tick     <= TICK_RELOAD;
        r_dur      <= w_entry_dur;
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end
    end else if (w_finish) begin
      r_state <= DONE;
      r_div   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b1;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_note_end) begin
            r_state <= GAP;
            r_div   <= '0;
            r_gap   <= GAP_RELOAD;
          end else if (r_tick == '0) begin
            r_tick <= TICK_RELOAD;
            r_dur  <= r_dur - 1'b1;
          end else begin
            r_tick <= r_tick - 1'b1;
          end
        end
        GAP: begin
          r_gap <= r_gap - 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq with TICK_DIV=4, GAP_CLKS=2.
// Stimulus pushes the expected div/busy/done/note_idx for every cycle of a
// scenario; the monitor pops one entry per cycle and compares.
module tb_melody_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [9:0] wr_div;
  logic [7:0] wr_dur;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] len;
  logic [9:0] div;
  logic       busy;
  logic       done;
  logic [2:0] note_idx;

  typedef struct {
    int tst;
    int cyc;
    int div;
    int busy;
    int done;
    int idx;   // -1 = not checked
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  melody_seq #(
    .WIDTH_COUNTER(10),
    .DEPTH(8),
    .WIDTH_DUR(8),
    .TICK_DIV(4),
    .GAP_CLKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_div(wr_div),
    .wr_dur(wr_dur),
    .start(start),
    .stop(stop),
    .loop(loop),
    .len(len),
    .div(div),
    .busy(busy),
    .done(done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_checks++;
      if ((int'(div) != m_e.div) || (int'(busy) != m_e.busy) || (int'(done) != m_e.done) ||
          ((m_e.idx >= 0) && (int'(note_idx) != m_e.idx))) begin
        n_fail++;
        $display("FAIL t%0d_c%0d: got div=%0d busy=%0d done=%0d idx=%0d, expected div=%0d busy=%0d done=%0d idx=%0d",
                 m_e.tst, m_e.cyc, div, busy, done, note_idx, m_e.div, m_e.busy, m_e.done, m_e.idx);
      end
    end
  end

  task automatic push(input int tst, input int from_c, input int to_c,
                      input int d, input int b, input int dn, input int idx);
    for (int c = from_c; c <= to_c; c++) begin
      exp_t e;
      e.tst  = tst;
      e.cyc  = c;
      e.div  = d;
      e.busy = b;
      e.done = dn;
      e.idx  = idx;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int tst);
    int n;
    n = 0;
    while ((q.size() > 0) && (n < 500)) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL t%0d_drain: %0d entries left, expected 0", tst, q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic wr(input int a, input int d, input int du);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_div  = 10'(d);
    wr_dur  = 8'(du);
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
    repeat (3) step();
    rst = 1'b0;

    // 1: idle after reset
    push(1, 0, 5, 0, 0, 0, 0);
    drain(1);

    // 2: three notes, single shot
    wr(0, 5, 2); wr(1, 7, 1); wr(2, 9, 3);
    len = 4'd3; loop = 1'b0; start = 1'b1;
    push(2, 0, 0, 0, 0, 0, -1);
    push(2, 1, 8, 5, 1, 0, 0);
    push(2, 9, 10, 0, 1, 0, 0);
    push(2, 11, 14, 7, 1, 0, 1);
    push(2, 15, 16, 0, 1, 0, 1);
    push(2, 17, 28, 9, 1, 0, 2);
    push(2, 29, 30, 0, 1, 0, 2);
    push(2, 31, 31, 0, 1, 1, -1);
    push(2, 32, 34, 0, 0, 0, -1);
    step(); start = 1'b0;
    drain(2);

    // 3: looping single note, stopped at c10
    wr(0, 3, 1);
    len = 4'd1; loop = 1'b1; start = 1'b1;
    push(3, 0, 0, 0, 0, 0, -1);
    push(3, 1, 4, 3, 1, 0, 0);
    push(3, 5, 6, 0, 1, 0, 0);
    push(3, 7, 10, 3, 1, 0, 0);
    push(3, 11, 14, 0, 0, 0, -1);
    step(); start = 1'b0; loop = 1'b0;
    repeat (9) step();
    stop = 1'b1;
    step(); stop = 1'b0;
    drain(3);

    // 4: end marker at entry 1
    wr(0, 4, 1); wr(1, 6, 0); wr(2, 8, 1);
    len = 4'd3; start = 1'b1;
    push(4, 0, 0, 0, 0, 0, -1);
    push(4, 1, 4, 4, 1, 0, 0);
    push(4, 5, 6, 0, 1, 0, 0);
    push(4, 7, 7, 0, 1, 1, -1);
    push(4, 8, 10, 0, 0, 0, -1);
    step(); start = 1'b0;
    drain(4);

    // 5a: start with len=0 ignored
    len = 4'd0; start = 1'b1;
    push(5, 0, 4, 0, 0, 0, -1);
    step(); start = 1'b0;
    drain(5);

    // 5b: start with stop in IDLE ignored
    len = 4'd3; start = 1'b1; stop = 1'b1;
    push(5, 0, 4, 0, 0, 0, -1);
    step(); start = 1'b0; stop = 1'b0;
    drain(5);

    // 5c: second start during PLAY does not restart
    len = 4'd1; start = 1'b1;
    push(5, 0, 0, 0, 0, 0, -1);
    push(5, 1, 4, 4, 1, 0, 0);
    push(5, 5, 6, 0, 1, 0, 0);
    push(5, 7, 7, 0, 1, 1, -1);
    push(5, 8, 9, 0, 0, 0, -1);
    step(); start = 1'b0;
    step(); start = 1'b1;
    step(); start = 1'b0;
    drain(5);

    // 7: len above DEPTH clamps to all eight entries
    for (int k = 0; k < 8; k++) wr(k, k + 1, 1);
    len = 4'd15; start = 1'b1;
    push(7, 0, 0, 0, 0, 0, -1);
    for (int k = 0; k < 8; k++) begin
      push(7, 1 + 6 * k, 4 + 6 * k, k + 1, 1, 0, k);
      push(7, 5 + 6 * k, 6 + 6 * k, 0, 1, 0, k);
    end
    push(7, 49, 49, 0, 1, 1, -1);
    push(7, 50, 51, 0, 0, 0, -1);
    step(); start = 1'b0;
    drain(7);

    // 6: reset mid-note clears the program
    wr(0, 4, 1);
    len = 4'd1; start = 1'b1;
    push(6, 0, 0, 0, 0, 0, -1);
    push(6, 1, 2, 4, 1, 0, 0);
    push(6, 3, 5, 0, 0, 0, 0);
    step(); start = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    drain(6);

    len = 4'd2; start = 1'b1;
    push(6, 0, 0, 0, 0, 0, -1);
    push(6, 1, 1, 0, 1, 1, -1);
    push(6, 2, 3, 0, 0, 0, -1);
    step(); start = 1'b0;
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
